// File: rtl/control_fsm.sv
// Multicycle main control unit for the RV64 datapath: sequences fetch/decode/execute/memory/
// writeback, stalls on memory ready, halts on illegal instructions and counts retirements.
module control_fsm #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             LoadAOut,
  output logic             RegWrite,
  output logic             LoadRegA,
  output logic             LoadRegB,
  output logic             MemToReg,
  output logic             DMemRead,
  output logic             DMemWrite,
  output logic             LoadMDR,
  output logic             IMemRead,
  output logic             IRWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSd  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
    StExecR, StExecI, StAluWb, StBranch, StHalt
  } state_e;

  state_e             state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    MemToReg    = 1'b0;
    DMemRead    = 1'b0;
    DMemWrite   = 1'b0;
    LoadMDR     = 1'b0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    // Every flag is held low for as long as reset is asserted.
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          IMemRead = 1'b1;
          ALUSrcB  = 2'b01;
          if (imem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = 2'b11;
          LoadAOut = 1'b1;
          unique case (opcode)
            OpLd, OpSd: state_d = StMemAddr;
            OpR:        state_d = StExecR;
            OpI:        state_d = StExecI;
            OpBeq:      state_d = (funct3 == 3'b000) ? StBranch : StHalt;
            default:    state_d = StHalt;
          endcase
        end
        StMemAddr: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          LoadAOut = 1'b1;
          // IR is stable past fetch; bit 5 separates SD from LD.
          state_d  = opcode[5] ? StMemWr : StMemRd;
        end
        StMemRd: begin
          DMemRead = 1'b1;
          if (dmem_ready) begin
            LoadMDR = 1'b1;
            state_d = StMemWb;
          end
        end
        StMemWb: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          retire   = 1'b1;
          state_d  = StFetch;
        end
        StMemWr: begin
          DMemWrite = 1'b1;
          if (dmem_ready) begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
        StExecR: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b10;
          LoadAOut = 1'b1;
          state_d  = StAluWb;
        end
        StExecI: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          ALUOp    = 2'b11;
          LoadAOut = 1'b1;
          state_d  = StAluWb;
        end
        StAluWb: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = StFetch;
        end
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          retire      = 1'b1;
          state_d     = StFetch;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StHalt) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected flag vectors are queued with their
// stimulus and compared as the DUT steps; a CNT_W=4 instance covers counter wrap.
module tb_control_fsm;

  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSd  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  // {PCWrite,PCWriteCond,PCSource,ALUSrcA,ALUSrcB,ALUOp,LoadAOut,RegWrite,LoadRegA,LoadRegB,
  //  MemToReg,DMemRead,DMemWrite,LoadMDR,IMemRead,IRWrite}
  localparam logic [18:0] FZero  = 19'b0_0_00_0_00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [18:0] FFw    = 19'b0_0_00_0_01_00_0_0_0_0_0_0_0_0_1_0;
  localparam logic [18:0] FFr    = 19'b1_0_00_0_01_00_0_0_0_0_0_0_0_0_1_1;
  localparam logic [18:0] FDec   = 19'b0_0_00_0_11_00_1_0_1_1_0_0_0_0_0_0;
  localparam logic [18:0] FMaddr = 19'b0_0_00_1_10_00_1_0_0_0_0_0_0_0_0_0;
  localparam logic [18:0] FMrdW  = 19'b0_0_00_0_00_00_0_0_0_0_0_1_0_0_0_0;
  localparam logic [18:0] FMrdR  = 19'b0_0_00_0_00_00_0_0_0_0_0_1_0_1_0_0;
  localparam logic [18:0] FMwb   = 19'b0_0_00_0_00_00_0_1_0_0_1_0_0_0_0_0;
  localparam logic [18:0] FMwr   = 19'b0_0_00_0_00_00_0_0_0_0_0_0_1_0_0_0;
  localparam logic [18:0] FExR   = 19'b0_0_00_1_00_10_1_0_0_0_0_0_0_0_0_0;
  localparam logic [18:0] FExI   = 19'b0_0_00_1_10_11_1_0_0_0_0_0_0_0_0_0;
  localparam logic [18:0] FAwb   = 19'b0_0_00_0_00_00_0_1_0_0_0_0_0_0_0_0;
  localparam logic [18:0] FBr    = 19'b0_1_01_1_00_01_0_0_0_0_0_0_0_0_0_0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;

  logic PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg;
  logic DMemRead, DMemWrite, LoadMDR, IMemRead, IRWrite, illegal;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [63:0] retired;

  logic w_pcw, w_pcwc, w_asa, w_lao, w_rw, w_lra, w_lrb, w_m2r, w_dr, w_dw, w_lmdr, w_imr;
  logic w_irw, w_ill;
  logic [1:0] w_pcs, w_asb, w_aop;
  logic [3:0] retired4;

  logic [18:0] obs;
  assign obs = {PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp, LoadAOut, RegWrite,
                LoadRegA, LoadRegB, MemToReg, DMemRead, DMemWrite, LoadMDR, IMemRead, IRWrite};

  control_fsm #(.CNT_W(64)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .LoadAOut(LoadAOut), .RegWrite(RegWrite),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .MemToReg(MemToReg), .DMemRead(DMemRead),
    .DMemWrite(DMemWrite), .LoadMDR(LoadMDR), .IMemRead(IMemRead), .IRWrite(IRWrite),
    .illegal(illegal), .retired(retired)
  );

  control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .PCSource(w_pcs), .ALUSrcA(w_asa),
    .ALUSrcB(w_asb), .ALUOp(w_aop), .LoadAOut(w_lao), .RegWrite(w_rw),
    .LoadRegA(w_lra), .LoadRegB(w_lrb), .MemToReg(w_m2r), .DMemRead(w_dr),
    .DMemWrite(w_dw), .LoadMDR(w_lmdr), .IMemRead(w_imr), .IRWrite(w_irw),
    .illegal(w_ill), .retired(retired4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [18:0] exp;
    bit          im;
    bit          dm;
  } cyc_t;

  cyc_t        sq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_ret = 64'd0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input string nm, input logic [18:0] exp, input bit im, input bit dm);
    cyc_t c;
    c.nm = nm; c.exp = exp; c.im = im; c.dm = dm;
    sq.push_back(c);
  endtask

  // Queue the expected per-cycle flags of one instruction; ready is random where it must be ignored.
  task automatic push_instr(input logic [6:0] opc, input logic [2:0] f3, input int iw,
                            input int dw);
    for (int i = 0; i < iw; i++) push("fetch_wait", FFw, 1'b0, rb());
    push("fetch", FFr, 1'b1, rb());
    push("decode", FDec, rb(), rb());
    case (opc)
      OpLd: begin
        push("mem_addr", FMaddr, rb(), rb());
        for (int i = 0; i < dw; i++) push("mem_rd_wait", FMrdW, rb(), 1'b0);
        push("mem_rd", FMrdR, rb(), 1'b1);
        push("mem_wb", FMwb, rb(), rb());
        exp_ret++;
      end
      OpSd: begin
        push("mem_addr", FMaddr, rb(), rb());
        for (int i = 0; i < dw; i++) push("mem_wr_wait", FMwr, rb(), 1'b0);
        push("mem_wr", FMwr, rb(), 1'b1);
        exp_ret++;
      end
      OpR: begin
        push("exec_r", FExR, rb(), rb());
        push("alu_wb", FAwb, rb(), rb());
        exp_ret++;
      end
      OpI: begin
        push("exec_i", FExI, rb(), rb());
        push("alu_wb", FAwb, rb(), rb());
        exp_ret++;
      end
      OpBeq: begin
        if (f3 == 3'b000) begin
          push("branch", FBr, rb(), rb());
          exp_ret++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_queue();
    cyc_t c;
    while (sq.size() > 0) begin
      c = sq.pop_front();
      imem_ready = c.im;
      dmem_ready = c.dm;
      @(negedge clk);
      n_tests++;
      if (obs !== c.exp) begin
        n_fail++;
        $display("FAIL flags_%s: got %b expected %b", c.nm, obs, c.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string nm, input logic exp_ill);
    n_tests++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL retired_%s: got %0d expected %0d", nm, retired, exp_ret);
    end
    n_tests++;
    if (illegal !== exp_ill) begin
      n_fail++;
      $display("FAIL illegal_%s: got %b expected %b", nm, illegal, exp_ill);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #3;
    exp_ret = 64'd0;
    n_tests++;
    if (obs !== FZero) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected %b", obs, FZero);
    end
    check_counts("reset", 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    opcode = 7'b0;
    push("fetch_after_reset", FFw, 1'b0, 1'b0);
    run_queue();
  endtask

  task automatic test_alu_r();
    opcode = OpR; funct3 = 3'b000;
    push_instr(OpR, 3'b000, 0, 0);
    run_queue();
    check_counts("alu_r", 1'b0);
  endtask

  task automatic test_load_stall();
    opcode = OpLd; funct3 = 3'b011;
    push_instr(OpLd, 3'b011, 0, 3);
    run_queue();
    check_counts("ld_stall", 1'b0);
  endtask

  task automatic test_back_to_back();
    opcode = OpSd; funct3 = 3'b011;
    push_instr(OpSd, 3'b011, 1, 2);
    run_queue();
    opcode = OpI; funct3 = 3'b000;
    push_instr(OpI, 3'b000, 2, 0);
    run_queue();
    opcode = OpBeq; funct3 = 3'b000;
    push_instr(OpBeq, 3'b000, 0, 0);
    run_queue();
    opcode = OpLd; funct3 = 3'b011;
    push_instr(OpLd, 3'b011, 0, 0);
    run_queue();
    check_counts("back_to_back", 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    opcode = OpLd; funct3 = 3'b011;
    push("fetch", FFr, 1'b1, 1'b0);
    push("decode", FDec, 1'b0, 1'b0);
    push("mem_addr", FMaddr, 1'b0, 1'b0);
    push("mem_rd_wait", FMrdW, 1'b0, 1'b0);
    push("mem_rd_wait", FMrdW, 1'b0, 1'b0);
    run_queue();
    check_counts("before_abort", 1'b0);
    do_reset();
    push("fetch_after_abort", FFw, 1'b0, 1'b1);
    run_queue();
  endtask

  task automatic test_beq_bad_funct3();
    opcode = OpBeq; funct3 = 3'b001;
    push_instr(OpBeq, 3'b001, 0, 0);
    for (int i = 0; i < 3; i++) push("halt_beq", FZero, rb(), rb());
    run_queue();
    check_counts("beq_f3", 1'b1);
    do_reset();
  endtask

  task automatic test_halt();
    opcode = OpR; funct3 = 3'b000;
    push_instr(OpR, 3'b000, 0, 0);
    run_queue();
    opcode = 7'b1111111;
    push_instr(7'b1111111, 3'b000, 0, 0);
    for (int i = 0; i < 20; i++) push("halt", FZero, 1'(i % 2), rb());
    run_queue();
    check_counts("halt", 1'b1);
    do_reset();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      opcode = (i % 2 == 0) ? OpR : OpI;
      funct3 = 3'b000;
      push_instr(opcode, 3'b000, int'($urandom_range(0, 1)), 0);
      run_queue();
      if (i == 14) begin
        n_tests++;
        if (retired4 !== 4'hF) begin
          n_fail++;
          $display("FAIL wrap_pre: got %0d expected 15", retired4);
        end
      end
    end
    n_tests++;
    if (retired4 !== 4'h0) begin
      n_fail++;
      $display("FAIL wrap: got %0d expected 0", retired4);
    end
    check_counts("wrap_wide", 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu_r();
    test_load_stall();
    test_back_to_back();
    test_reset_mid_wait();
    test_beq_bad_funct3();
    test_halt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
